// File: rtl/ppwm_exec_v2_if.sv
// Instruction fetch bus between the PWM sequencer core and its instruction store.
// The store must return instr_i for pc_o in the same cycle, or hold instr_valid_i low.
interface ppwm_exec_v2_if #(
  parameter int PC_WIDTH    = 5,
  parameter int INSTR_WIDTH = 8
);
  logic [PC_WIDTH-1:0]    pc_o;
  logic [INSTR_WIDTH-1:0] instr_i;
  logic                   instr_valid_i;

  // Handshake: the core presents pc_o; an instruction executes only in a cycle where
  // instr_valid_i is high, and low means stall with all core state held.
  modport master (output pc_o, input instr_i, input instr_valid_i);
  modport slave  (input pc_o, output instr_i, output instr_valid_i);
endinterface

// File: rtl/ppwm_exec_v2.sv
// Programmable PWM sequencer core: runs a short program once per PWM period to compute duty.
// Build option PPWM_EXEC_SAT_ADD_EN makes ADD saturate instead of wrap.
module ppwm_exec_v2 #(
  parameter int COUNTER_WIDTH = 8,
  parameter int PC_WIDTH      = 5,
  parameter int INSTR_WIDTH   = 8,
  parameter int MAX_STEPS     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [COUNTER_WIDTH-1:0] global_counter_i,
  ppwm_exec_v2_if.master           fetch,
  output logic [COUNTER_WIDTH-1:0] pwm_value_o,
  output logic                     busy_o,
  output logic                     overrun_o,
  output logic [1:0]               dbg_state_o
);
  localparam int IMM_W  = INSTR_WIDTH - 4;
  localparam int OFF_W  = INSTR_WIDTH - 3;
  localparam int SUM_W  = (OFF_W > PC_WIDTH) ? OFF_W : PC_WIDTH;
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [PC_WIDTH-1:0] PC_LAST   = '1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(MAX_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_SET, OP_ADD, OP_SHIFT, OP_WAIT, OP_JUMP, OP_CMP, OP_BRANCH
  } op_t;

  state_t                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic                     flag_q, flag_d;
  logic [COUNTER_WIDTH-1:0] reg_q, reg_d;
  logic [COUNTER_WIDTH-1:0] pwm_q, pwm_d;
  logic [COUNTER_WIDTH-1:0] pwm_value_q, pwm_value_d;
  logic                     overrun_q, overrun_d;

  op_t                      opcode;
  logic                     tgt;
  logic [IMM_W-1:0]         imm;
  logic [OFF_W-1:0]         off_raw;
  logic [SUM_W-1:0]         off_ext;
  logic [PC_WIDTH-1:0]      pc_seq;
  logic [PC_WIDTH-1:0]      pc_jump;
  logic [COUNTER_WIDTH-1:0] t_val;
  logic [COUNTER_WIDTH-1:0] alu_val;
  logic [COUNTER_WIDTH:0]   add_sum;
  logic [IMM_W-2:0]         sh_amt;
  logic                     taken;

  assign opcode  = op_t'(fetch.instr_i[2:0]);
  assign tgt     = fetch.instr_i[3];
  assign imm     = fetch.instr_i[INSTR_WIDTH-1:4];
  // Branch offset reuses the target bit as its LSB, giving one extra bit of reach.
  assign off_raw = {imm, tgt};
  assign off_ext = SUM_W'($signed(off_raw));
  assign pc_seq  = pc_q + PC_WIDTH'(1);
  assign pc_jump = pc_q + off_ext[PC_WIDTH-1:0];

  assign t_val   = tgt ? pwm_q : reg_q;
  assign add_sum = {1'b0, t_val} + (COUNTER_WIDTH + 1)'(imm);
  assign sh_amt  = imm[IMM_W-1:1];

  always_comb begin
    alu_val = t_val;
    case (opcode)
      OP_SET: alu_val = COUNTER_WIDTH'(imm);
      OP_ADD: begin
`ifdef PPWM_EXEC_SAT_ADD_EN
        alu_val = add_sum[COUNTER_WIDTH] ? '1 : add_sum[COUNTER_WIDTH-1:0];
`else
        alu_val = add_sum[COUNTER_WIDTH-1:0];
`endif
      end
      OP_SHIFT: begin
        if (32'(sh_amt) >= COUNTER_WIDTH) alu_val = '0;
        else if (imm[0])                  alu_val = t_val << sh_amt;
        else                              alu_val = t_val >> sh_amt;
      end
      default: alu_val = t_val;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    step_d      = step_q;
    flag_d      = flag_q;
    reg_d       = reg_q;
    pwm_d       = pwm_q;
    pwm_value_d = pwm_value_q;
    overrun_d   = 1'b0;
    taken       = 1'b0;

    // The working register can never change in a start_i cycle, so this copy is stable.
    if (start_i) pwm_value_d = pwm_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_EXEC;
          pc_d    = '0;
          step_d  = '0;
        end
      end
      ST_WAIT: begin
        if (start_i) begin
          state_d = ST_EXEC;
          step_d  = '0;
        end
      end
      ST_EXEC: begin
        if (start_i) begin
          pc_d      = '0;
          step_d    = '0;
          overrun_d = 1'b1;
        end else if (fetch.instr_valid_i) begin
          step_d = step_q + STEP_W'(1);
          pc_d   = pc_seq;
          case (opcode)
            OP_SET, OP_ADD, OP_SHIFT: begin
              if (tgt) pwm_d = alu_val;
              else     reg_d = alu_val;
            end
            OP_JUMP: begin
              pc_d  = pc_jump;
              taken = 1'b1;
            end
            OP_CMP: flag_d = (global_counter_i < t_val);
            OP_BRANCH: begin
              if (flag_q) begin
                pc_d  = pc_jump;
                taken = 1'b1;
              end
            end
            default: ;
          endcase
          // Leaving EXEC normally takes priority; the budget only stops a program still running.
          if (opcode == OP_WAIT) begin
            state_d = ST_WAIT;
          end else if (!taken && (pc_q == PC_LAST)) begin
            state_d = ST_IDLE;
          end else if (step_q == STEP_LAST) begin
            state_d   = ST_WAIT;
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      step_q      <= '0;
      flag_q      <= 1'b0;
      reg_q       <= '0;
      pwm_q       <= '0;
      pwm_value_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      step_q      <= step_d;
      flag_q      <= flag_d;
      reg_q       <= reg_d;
      pwm_q       <= pwm_d;
      pwm_value_q <= pwm_value_d;
      overrun_q   <= overrun_d;
    end
  end

  assign fetch.pc_o  = pc_q;
  assign pwm_value_o = pwm_value_q;
  assign busy_o      = (state_q == ST_EXEC);
  assign overrun_o   = overrun_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ppwm_exec_v2.sv
// Bench for ppwm_exec_v2: directed program scenarios, then random programs and inputs,
// all compared cycle by cycle against an arithmetic model of the sequencer.
module tb_ppwm_exec_v2;
  localparam int CW = 8;
  localparam int PW = 5;
  localparam int IW = 8;
  localparam int MAX_STEPS = 4;
  localparam int DEPTH = 32;
  localparam int M_IDLE = 0;
  localparam int M_EXEC = 1;
  localparam int M_WAIT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic [CW-1:0] gc = '0;
  logic [IW-1:0] prog [DEPTH];
  logic [CW-1:0] pwm_value;
  logic          busy;
  logic          overrun;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  int m_mode, m_pc, m_steps, m_flag, m_reg, m_pwm, m_duty, m_ovr;

  ppwm_exec_v2_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) fetch_if ();

  assign fetch_if.instr_i       = prog[fetch_if.pc_o];
  assign fetch_if.instr_valid_i = valid;

  ppwm_exec_v2 #(
    .COUNTER_WIDTH(CW), .PC_WIDTH(PW), .INSTR_WIDTH(IW), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .global_counter_i (gc),
    .fetch            (fetch_if),
    .pwm_value_o      (pwm_value),
    .busy_o           (busy),
    .overrun_o        (overrun),
    .dbg_state_o      (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one clock of the sequencer expressed directly from the instruction rules.
  task automatic model_step();
    int ins, op, t, imm, off, tv, nv, npc, tk, s, amt;
    m_ovr = 0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pc = 0; m_steps = 0; m_flag = 0;
      m_reg = 0; m_pwm = 0; m_duty = 0;
      return;
    end
    if (start) m_duty = m_pwm;
    if (m_mode == M_IDLE) begin
      if (start) begin m_mode = M_EXEC; m_pc = 0; m_steps = 0; end
    end else if (m_mode == M_WAIT) begin
      if (start) begin m_mode = M_EXEC; m_steps = 0; end
    end else if (start) begin
      m_pc = 0; m_steps = 0; m_ovr = 1;
    end else if (valid) begin
      ins = int'(prog[m_pc]);
      op  = ins % 8;
      t   = (ins / 8) % 2;
      imm = ins / 16;
      off = imm * 2 + t;
      if (off >= 16) off = off - 32;
      tv  = (t == 1) ? m_pwm : m_reg;
      nv  = tv;
      npc = (m_pc + 1) % DEPTH;
      tk  = 0;
      case (op)
        1: nv = imm;
        2: begin
          s = tv + imm;
`ifdef PPWM_EXEC_SAT_ADD_EN
          nv = (s > 255) ? 255 : s;
`else
          nv = s % 256;
`endif
        end
        3: begin
          amt = imm / 2;
          if (amt >= CW)         nv = 0;
          else if (imm % 2 == 1) nv = (tv * (1 << amt)) % 256;
          else                   nv = tv / (1 << amt);
        end
        5: begin npc = (m_pc + off + DEPTH) % DEPTH; tk = 1; end
        6: m_flag = (int'(gc) < tv) ? 1 : 0;
        7: if (m_flag == 1) begin npc = (m_pc + off + DEPTH) % DEPTH; tk = 1; end
        default: ;
      endcase
      if (op >= 1 && op <= 3) begin
        if (t == 1) m_pwm = nv;
        else        m_reg = nv;
      end
      m_steps++;
      if (op == 4)                       m_mode = M_WAIT;
      else if (tk == 0 && m_pc == DEPTH - 1) m_mode = M_IDLE;
      else if (m_steps == MAX_STEPS) begin m_mode = M_WAIT; m_ovr = 1; end
      m_pc = npc;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("pc", 32'(fetch_if.pc_o), 32'(m_pc));
    chk("duty", 32'(pwm_value), 32'(m_duty));
    chk("busy", 32'(busy), 32'(m_mode == M_EXEC));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic step(input logic st, input logic v);
    start = st;
    valid = v;
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; valid = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic prog_clear();
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'h04;
  endtask

  initial begin
    // Reset and SET/ADD/WAIT with duty commit on the following start.
    prog_clear();
    prog[0] = 8'h59; prog[1] = 8'h3A; prog[2] = 8'h04;
    do_reset();
    chk("reset_pc", 32'(fetch_if.pc_o), 0);
    chk("reset_duty", 32'(pwm_value), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ovr", 32'(overrun), 0);
    chk("reset_state", 32'(dbg_state), 0);
    step(1'b1, 1'b1);
    chk("t1_busy", 32'(busy), 1);
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    chk("t1_pc_wait", 32'(fetch_if.pc_o), 3);
    chk("t1_busy_wait", 32'(busy), 0);
    chk("t1_duty_pre", 32'(pwm_value), 0);
    step(1'b1, 1'b1);
    chk("t1_duty_post", 32'(pwm_value), 8);
    step(1'b0, 1'b1);

    // ADD overflow: 15<<4 = 240, +10 = 250, then +15.
    prog_clear();
    prog[0] = 8'hF9; prog[1] = 8'h9B; prog[2] = 8'hAA; prog[3] = 8'h04;
    prog[4] = 8'hFA; prog[5] = 8'h04;
    do_reset();
    step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    chk("t2_no_ovr", 32'(overrun), 0);
    step(1'b1, 1'b1);
    chk("t2_duty250", 32'(pwm_value), 250);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b0);
`ifdef PPWM_EXEC_SAT_ADD_EN
    chk("t2_add_sat", 32'(pwm_value), 255);
`else
    chk("t2_add_wrap", 32'(pwm_value), 9);
`endif

    // SHIFT left 3 then right 7.
    prog_clear();
    prog[0] = 8'h39; prog[1] = 8'h7B; prog[2] = 8'h04; prog[3] = 8'hEB; prog[4] = 8'h04;
    do_reset();
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("t3_shl", 32'(pwm_value), 8'h18);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("t3_shr", 32'(pwm_value), 0);

    // CMP/BRANCH -2 taken (budget stops it), then CMP clears the flag and falls through.
    prog_clear();
    prog[0] = 8'hA1; prog[1] = 8'hA2; prog[2] = 8'h06; prog[3] = 8'hF7; prog[4] = 8'h04;
    do_reset();
    gc = 8'd10;
    step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    chk("t4_taken_pc", 32'(fetch_if.pc_o), 1);
    chk("t4_taken_ovr", 32'(overrun), 1);
    gc = 8'd30;
    step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    chk("t4_fall_pc", 32'(fetch_if.pc_o), 5);
    chk("t4_fall_ovr", 32'(overrun), 0);
    chk("t4_fall_busy", 32'(busy), 0);

    // Step budget on an infinite JUMP +0.
    prog_clear();
    prog[0] = 8'h05;
    do_reset();
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_ovr_early", 32'(overrun), 0);
    step(1'b0, 1'b1);
    chk("t5_ovr", 32'(overrun), 1);
    chk("t5_pc", 32'(fetch_if.pc_o), 0);
    step(1'b0, 1'b1);
    chk("t5_ovr_once", 32'(overrun), 0);
    chk("t5_idle_busy", 32'(busy), 0);

    // start_i during EXEC suppresses the instruction; stalls hold everything.
    prog_clear();
    prog[0] = 8'h19; prog[1] = 8'h1A; prog[2] = 8'h99;
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("t6_stall_pc", 32'(fetch_if.pc_o), 1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("t6_restart_pc", 32'(fetch_if.pc_o), 0);
    chk("t6_restart_ovr", 32'(overrun), 1);
    chk("t6_duty", 32'(pwm_value), 2);
    step(1'b0, 1'b0);
    chk("t6_ovr_clear", 32'(overrun), 0);
    step(1'b1, 1'b0);
    chk("t6_suppressed", 32'(pwm_value), 2);
    chk("t6_ovr2", 32'(overrun), 1);

    // Random programs and inputs against the model.
    do_reset();
    for (int n = 0; n < 2400; n++) begin
      if (n % 400 == 0) begin
        for (int i = 0; i < DEPTH; i++) prog[i] = IW'($urandom_range(0, 255));
      end
      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 9) == 0);
      valid = ($urandom_range(0, 3) != 0);
      gc    = CW'($urandom_range(0, 255));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
